aip_responder: RTL
==================

AIP_RESPONDER -- requirements
Module: aip_responder

Interface
REQ-001 Parameter IP_ID, 32'h0000_1001, constant returned on ID reads.
REQ-002 Parameter MEMIN_DEPTH, 16, words in input buffer (power of two).
REQ-003 Parameter MEMOUT_DEPTH, 16, words in output buffer (power of two).
REQ-004 Clocking: one clock; reset asynchronous, active-low.
REQ-005 clk  in  1  clock, all state on rising edge.
REQ-006 rst_a  in  1  asynchronous active-low reset.
REQ-007 en_s  in  1  AIP enable; when low, read/write/start are ignored.
REQ-008 conf_dbus  in  5  AIP target select.
REQ-009 read  in  1  AIP read strobe, one word per cycle high.
REQ-010 write  in  1  AIP write strobe, one word per cycle high.
REQ-011 start  in  1  AIP start strobe.
REQ-012 data_in  in  32  AIP write data.
REQ-013 data_out  out  32  AIP read data, registered.
REQ-014 int_req  out  1  interrupt request to NIC.
REQ-015 core_rd_addr  in  log2(MEMIN_DEPTH)  core read address into input buffer.
REQ-016 core_rd_data  out  32  input buffer word, one cycle after core_rd_addr.
REQ-017 core_wr_en / core_wr_addr / core_wr_data  in  1 / log2(MEMOUT_DEPTH) / 32  core write port to output buffer.
REQ-018 core_conf  out  32  configuration register value.
REQ-019 core_start  out  1  one-cycle start pulse to core.
REQ-020 core_done  in  1  one-cycle completion pulse from core.

Function
REQ-021 Codes: 5'h00 MEMIN (write), 5'h01 MEMOUT (read), 5'h02 CONF (read/write), 5'h1E STATUS (read/write), 5'h1F ID (read-only); other codes: writes ignored, reads return 0.
REQ-022 Write to MEMIN stores data_in at wr_ptr; wr_ptr increments, wraps MEMIN_DEPTH-1 -> 0.
REQ-023 Read of MEMOUT returns word at rd_ptr on data_out the next cycle; rd_ptr increments, wraps MEMOUT_DEPTH-1 -> 0.
REQ-024 Any cycle where conf_dbus differs from its previous-cycle value clears wr_ptr and rd_ptr to 0; if an access occurs in that same cycle, it uses index 0 and the pointer becomes 1.
REQ-025 Read latency: data_out updates exactly one cycle after read high; it holds its value while read is low.
REQ-026 read and write both high: the write is performed and the read is ignored (data_out holds, rd_ptr unchanged).
REQ-027 STATUS read: bit0 done (sticky), bit1 busy, bit16 int_en, other bits 0.
REQ-028 STATUS write: bit0=1 clears done (W1C); bit16 loads int_en.
REQ-029 FSM IDLE -> RUN on start & en_s & !busy: core_start pulses one cycle, busy=1, done cleared.
REQ-030 start while RUN is ignored and produces no core_start.
REQ-031 RUN -> IDLE on core_done: busy=0, done=1; core_done in IDLE also sets done.
REQ-032 core_done and a STATUS W1C in the same cycle: done ends at 1 (set wins).
REQ-033 int_req = done & int_en, registered, asserted one cycle after done is set.
REQ-034 Core write to MEMOUT and AIP read of MEMOUT at the same address in the same cycle return the old word.

Reset
REQ-035 Reset values: data_out=0, int_req=0, core_start=0, core_conf=0, wr_ptr=0, rd_ptr=0, done=0, busy=0, int_en=0, FSM=IDLE.
REQ-036 Buffer contents are not reset.
REQ-037 Reset asserted in RUN returns the block to IDLE; a core_done arriving after reset release only sets done.

Structure
REQ-038 Config codes, STATUS bit positions and FSM encodings are defined in the shared include aip_defs.
REQ-039 Both buffers instantiate one sub-module, aip_dpram: one write port, one registered read port, parameterised depth and width.

Verification
REQ-040 Write 0xA0..0xAF to MEMIN, then core reads addresses 0..15 -> core_rd_data returns 0xA0..0xAF; a 17th AIP write overwrites index 0.
REQ-041 Core writes 0x100+i to MEMOUT[i]; select MEMOUT; 16 back-to-back reads -> data_out returns 0x100..0x10F, each one cycle after its read.
REQ-042 Write STATUS 0x0001_0000; pulse start -> one core_start pulse and busy=1; second start while busy -> no pulse; core_done -> done=1, int_req=1 the next cycle; write STATUS 0x1 -> int_req=0.
REQ-043 Same-cycle core_done and STATUS W1C -> done stays 1.
REQ-044 Read ID -> 0x0000_1001; read code 5'h07 -> 0; MEMIN writes with en_s=0 -> wr_ptr unchanged.
REQ-045 Assert rst_a low mid-RUN -> all outputs at reset values immediately; after release, state is IDLE.

Source files
------------

// File: rtl/aip_responder_pkg.sv
// Shared AIP definitions: target select codes, STATUS bit positions, FSM encoding
// and a helper that assembles the STATUS word.
package aip_responder_pkg;

  // AIP target select codes (conf_dbus)
  localparam logic [4:0] CodeMemin  = 5'h00;
  localparam logic [4:0] CodeMemout = 5'h01;
  localparam logic [4:0] CodeConf   = 5'h02;
  localparam logic [4:0] CodeStatus = 5'h1E;
  localparam logic [4:0] CodeId     = 5'h1F;

  // STATUS register bit positions
  localparam int unsigned StatusDoneBit  = 0;
  localparam int unsigned StatusBusyBit  = 1;
  localparam int unsigned StatusIntEnBit = 16;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } aip_state_e;

  function automatic logic [31:0] status_word(input logic done, input logic busy,
                                              input logic int_en);
    logic [31:0] w;
    w                 = '0;
    w[StatusDoneBit]  = done;
    w[StatusBusyBit]  = busy;
    w[StatusIntEnBit] = int_en;
    return w;
  endfunction

endpackage

// File: rtl/aip_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and write to the same address in one cycle returns the old word.
// Ports:
//   i_clk                                  clock
//   i_wr_en / i_wr_addr / i_wr_data        write port
//   i_rd_en / i_rd_addr                    read request (output updates only when enabled)
//   o_rd_data                              registered read data
module aip_dpram #(
  parameter  int unsigned Depth = 16,
  parameter  int unsigned Width = 32,
  localparam int unsigned Aw    = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [Aw-1:0]    i_wr_addr,
  input  logic [Width-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [Aw-1:0]    i_rd_addr,
  output logic [Width-1:0] o_rd_data
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rd_data;

  // Contents are intentionally not reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/aip_responder.sv
// AIP responder: bridges the AIP bus (MEMIN/MEMOUT buffers, CONF, STATUS, ID)
// to a compute core with a start/done handshake and an interrupt request.
// Ports:
//   i_clk, i_rst_a                         clock, async active-low reset
//   i_en_s, i_conf_dbus, i_read, i_write,
//   i_start, i_data_in, o_data_out         AIP side
//   o_int_req                              interrupt request (done & int_en)
//   i_core_rd_addr, o_core_rd_data         core read port of input buffer
//   i_core_wr_en/addr/data                 core write port of output buffer
//   o_core_conf, o_core_start, i_core_done core control
module aip_responder
  import aip_responder_pkg::*;
#(
  parameter  logic [31:0] IP_ID        = 32'h0000_1001,
  parameter  int unsigned MEMIN_DEPTH  = 16,
  parameter  int unsigned MEMOUT_DEPTH = 16,
  localparam int unsigned InAw         = $clog2(MEMIN_DEPTH),
  localparam int unsigned OutAw        = $clog2(MEMOUT_DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_a,
  input  logic             i_en_s,
  input  logic [4:0]       i_conf_dbus,
  input  logic             i_read,
  input  logic             i_write,
  input  logic             i_start,
  input  logic [31:0]      i_data_in,
  output logic [31:0]      o_data_out,
  output logic             o_int_req,
  input  logic [InAw-1:0]  i_core_rd_addr,
  output logic [31:0]      o_core_rd_data,
  input  logic             i_core_wr_en,
  input  logic [OutAw-1:0] i_core_wr_addr,
  input  logic [31:0]      i_core_wr_data,
  output logic [31:0]      o_core_conf,
  output logic             o_core_start,
  input  logic             i_core_done
);

  aip_state_e      r_state, w_state_d;
  logic [4:0]      r_conf_dbus;
  logic [InAw-1:0] r_wr_ptr, w_wr_idx;
  logic [OutAw-1:0] r_rd_ptr, w_rd_idx;
  logic [31:0]     r_conf, r_reg_rdata, w_reg_rdata, w_memout_q;
  logic            r_out_from_mem;
  logic            r_done, w_done_d, r_int_en, r_int_req, r_core_start;
  logic            w_busy, w_start_fire;
  logic            w_wr, w_rd, w_memin_wr, w_memout_rd, w_conf_wr, w_status_wr, w_w1c;

  // A change of target restarts both buffer pointers; an access in the same
  // cycle already uses index 0.
  assign w_wr_idx = (i_conf_dbus != r_conf_dbus) ? '0 : r_wr_ptr;
  assign w_rd_idx = (i_conf_dbus != r_conf_dbus) ? '0 : r_rd_ptr;

  // Write has priority over read when both strobes are high.
  assign w_wr        = i_en_s & i_write;
  assign w_rd        = i_en_s & i_read & ~i_write;
  assign w_memin_wr  = w_wr & (i_conf_dbus == CodeMemin);
  assign w_conf_wr   = w_wr & (i_conf_dbus == CodeConf);
  assign w_status_wr = w_wr & (i_conf_dbus == CodeStatus);
  assign w_memout_rd = w_rd & (i_conf_dbus == CodeMemout);
  assign w_w1c       = w_status_wr & i_data_in[StatusDoneBit];
  assign w_busy      = (r_state == StRun);

  always_comb begin
    w_state_d    = r_state;
    w_start_fire = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_en_s && i_start) begin
          w_start_fire = 1'b1;
          w_state_d    = StRun;
        end
      end
      StRun: begin
        if (i_core_done) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Set from core_done wins over both clear sources.
  always_comb begin
    w_done_d = r_done;
    if (w_start_fire || w_w1c) w_done_d = 1'b0;
    if (i_core_done) w_done_d = 1'b1;
  end

  always_comb begin
    w_reg_rdata = '0;
    unique case (i_conf_dbus)
      CodeConf:   w_reg_rdata = r_conf;
      CodeStatus: w_reg_rdata = status_word(r_done, w_busy, r_int_en);
      CodeId:     w_reg_rdata = IP_ID;
      default:    w_reg_rdata = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_a) begin
    if (!i_rst_a) begin
      r_state        <= StIdle;
      r_conf_dbus    <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_conf         <= '0;
      r_reg_rdata    <= '0;
      r_out_from_mem <= 1'b0;
      r_done         <= 1'b0;
      r_int_en       <= 1'b0;
      r_int_req      <= 1'b0;
      r_core_start   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_conf_dbus  <= i_conf_dbus;
      r_wr_ptr     <= w_memin_wr ? w_wr_idx + InAw'(1) : w_wr_idx;
      r_rd_ptr     <= w_memout_rd ? w_rd_idx + OutAw'(1) : w_rd_idx;
      r_done       <= w_done_d;
      r_int_req    <= r_done & r_int_en;
      r_core_start <= w_start_fire;
      if (w_conf_wr) r_conf <= i_data_in;
      if (w_status_wr) r_int_en <= i_data_in[StatusIntEnBit];
      // Output source and register snapshot only move on an accepted read,
      // so data_out holds otherwise.
      if (w_rd) begin
        r_out_from_mem <= w_memout_rd;
        r_reg_rdata    <= w_reg_rdata;
      end
    end
  end

  assign o_data_out   = r_out_from_mem ? w_memout_q : r_reg_rdata;
  assign o_int_req    = r_int_req;
  assign o_core_conf  = r_conf;
  assign o_core_start = r_core_start;

  aip_dpram #(
    .Depth(MEMIN_DEPTH),
    .Width(32)
  ) u_memin (
    .i_clk    (i_clk),
    .i_wr_en  (w_memin_wr),
    .i_wr_addr(w_wr_idx),
    .i_wr_data(i_data_in),
    .i_rd_en  (1'b1),
    .i_rd_addr(i_core_rd_addr),
    .o_rd_data(o_core_rd_data)
  );

  aip_dpram #(
    .Depth(MEMOUT_DEPTH),
    .Width(32)
  ) u_memout (
    .i_clk    (i_clk),
    .i_wr_en  (i_core_wr_en),
    .i_wr_addr(i_core_wr_addr),
    .i_wr_data(i_core_wr_data),
    .i_rd_en  (w_memout_rd),
    .i_rd_addr(w_rd_idx),
    .o_rd_data(w_memout_q)
  );

endmodule
